// File: rtl/fpu_pkg.sv
// Shared binary64 constants, divider FSM states and operand classes.
package fpu_pkg;

    localparam logic [10:0] FP64_BIAS    = 11'd1023;
    localparam logic [63:0] FP64_QNAN    = 64'h7FF8000000000000;
    localparam logic [10:0] FP64_EXP_MAX = 11'h7FF;
    localparam int          QBITS        = 56;

    typedef enum logic [2:0] {IDLE, SPECIAL, DIV, ROUND, DONE} state_t;

    typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp64_class_t;

endpackage

// File: rtl/fp64_classify.sv
// Combinational binary64 operand classifier; exponent 0 (zero or subnormal) reports ZERO.
module fp64_classify
    import fpu_pkg::*;
(
    input  logic [63:0]  x,
    output fp64_class_t  cls
);

    logic unused_sign;
    assign unused_sign = x[63];

    always_comb begin
        cls = NORM;
        if (x[62:52] == 11'd0)
            cls = ZERO;
        else if (x[62:52] == FP64_EXP_MAX) begin
            if (x[51:0] == 52'd0)
                cls = INF;
            else if (x[51])
                cls = QNAN;
            else
                cls = SNAN;
        end
    end

endmodule

// File: rtl/ddiv_iter.sv
// Iterative binary64 divider (restoring radix-2, one quotient bit per clock); DDIV_ITER_FLAGS_EN adds fflags.
// Latency: out_valid 58 edges after accept for normal operands, 1 edge for special operands.
// Backpressure: in_ready only in IDLE; result and out_valid held stable until out_ready.
module ddiv_iter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out
`ifdef DDIV_ITER_FLAGS_EN
    ,
    output logic [4:0]  fflags
`endif
);

    state_t             state;
    logic [5:0]         cnt;
    logic [53:0]        rem;
    logic [52:0]        dvs;
    logic [QBITS-1:0]   quo;
    logic               sign_q;
    logic [10:0]        ea_q, eb_q;
    fp64_class_t        ca, cb, ca_q, cb_q;
    logic               rnd_ph;
    logic [51:0]        frac_q;
    logic signed [12:0] ex_q;

    logic        ge;
    logic [52:0] diff;
    logic        hi, g, r, s;
    logic [52:0] m0;
    logic [53:0] msum;
    logic [51:0] frac_r;
    logic [12:0] e0, e_r;
    logic [63:0] spec_out;
`ifdef DDIV_ITER_FLAGS_EN
    logic        spec_nv, spec_dz, nx_q;
`endif

    fp64_classify u_cls_a (.x(a), .cls(ca));
    fp64_classify u_cls_b (.x(b), .cls(cb));

    assign in_ready = (state == IDLE);

    // R < 2D always holds, so the difference fits in the low 53 bits.
    always_comb begin
        ge   = (rem >= {1'b0, dvs});
        diff = ge ? (rem[52:0] - dvs) : rem[52:0];
    end

    always_comb begin
        hi     = quo[QBITS-1];
        m0     = hi ? quo[55:3] : quo[54:2];
        g      = hi ? quo[2] : quo[1];
        r      = hi ? quo[1] : quo[0];
        s      = (hi & quo[0]) | (rem != 54'd0);
        e0     = {2'b00, ea_q} - {2'b00, eb_q}
               + (hi ? {2'b00, FP64_BIAS} : {2'b00, FP64_BIAS - 11'd1});
        msum   = {1'b0, m0} + {53'd0, g & (r | s | m0[0])};
        frac_r = msum[53] ? msum[52:1] : msum[51:0];
        e_r    = e0 + {12'd0, msum[53]};
    end

    always_comb begin
        spec_out = {sign_q, 63'd0};
`ifdef DDIV_ITER_FLAGS_EN
        spec_nv  = 1'b0;
        spec_dz  = 1'b0;
`endif
        if (ca_q inside {QNAN, SNAN} || cb_q inside {QNAN, SNAN}) begin
            spec_out = FP64_QNAN;
`ifdef DDIV_ITER_FLAGS_EN
            spec_nv  = (ca_q == SNAN) || (cb_q == SNAN);
`endif
        end else if ((ca_q == ZERO && cb_q == ZERO) || (ca_q == INF && cb_q == INF)) begin
            spec_out = FP64_QNAN;
`ifdef DDIV_ITER_FLAGS_EN
            spec_nv  = 1'b1;
`endif
        end else if (ca_q == INF) begin
            spec_out = {sign_q, FP64_EXP_MAX, 52'd0};
        end else if (cb_q == ZERO) begin
            spec_out = {sign_q, FP64_EXP_MAX, 52'd0};
`ifdef DDIV_ITER_FLAGS_EN
            spec_dz  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= 64'h0;
            cnt       <= 6'd0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            sign_q    <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            ca_q      <= ZERO;
            cb_q      <= ZERO;
            rnd_ph    <= 1'b0;
            frac_q    <= '0;
            ex_q      <= '0;
`ifdef DDIV_ITER_FLAGS_EN
            fflags    <= 5'd0;
            nx_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q <= a[63] ^ b[63];
                    ea_q   <= a[62:52];
                    eb_q   <= b[62:52];
                    rem    <= {2'b01, a[51:0]};
                    dvs    <= {1'b1, b[51:0]};
                    quo    <= '0;
                    ca_q   <= ca;
                    cb_q   <= cb;
                    cnt    <= 6'(QBITS - 1);
                    state  <= (ca == NORM && cb == NORM) ? DIV : SPECIAL;
                end
                SPECIAL: begin
                    out       <= spec_out;
                    out_valid <= 1'b1;
`ifdef DDIV_ITER_FLAGS_EN
                    fflags    <= {spec_nv, spec_dz, 3'b000};
`endif
                    state     <= DONE;
                end
                DIV: begin
                    rem <= {diff, 1'b0};
                    quo <= {quo[QBITS-2:0], ge};
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        rnd_ph <= 1'b0;
                        state  <= ROUND;
                    end
                end
                // First phase rounds, second range-checks and packs.
                ROUND: if (!rnd_ph) begin
                    frac_q <= frac_r;
                    ex_q   <= e_r;
`ifdef DDIV_ITER_FLAGS_EN
                    nx_q   <= g | r | s;
`endif
                    rnd_ph <= 1'b1;
                end else begin
                    if (ex_q >= 13'sd2047)
                        out <= {sign_q, FP64_EXP_MAX, 52'd0};
                    else if (ex_q <= 13'sd0)
                        out <= {sign_q, 63'd0};
                    else
                        out <= {sign_q, ex_q[10:0], frac_q};
`ifdef DDIV_ITER_FLAGS_EN
                    fflags <= {2'b00, ex_q >= 13'sd2047, ex_q <= 13'sd0,
                               nx_q | (ex_q >= 13'sd2047) | (ex_q <= 13'sd0)};
`endif
                    out_valid <= 1'b1;
                    rnd_ph    <= 1'b0;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddiv_iter.sv
// Self-checking bench for ddiv_iter: directed cases plus random operands against a real-arithmetic model.
module tb_ddiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
`ifdef DDIV_ITER_FLAGS_EN
    logic [4:0]  fflags;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef DDIV_ITER_FLAGS_EN
        ,
        .fflags    (fflags)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] flush(input logic [63:0] x);
        return (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
    endfunction

    function automatic bit is_norm(input logic [63:0] x);
        return x[62:52] != 11'd0 && x[62:52] != 11'h7FF;
    endfunction

    function automatic bit is_nan(input logic [63:0] x);
        return x[62:52] == 11'h7FF && x[51:0] != 52'd0;
    endfunction

    // IEEE double division by the host, then the divider's canonical-NaN and flush-to-zero rules.
    function automatic logic [63:0] ref_div(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] res;
        res = $realtobits($bitstoreal(flush(x)) / $bitstoreal(flush(y)));
        if (is_nan(res))
            return 64'h7FF8000000000000;
        if (res[62:52] == 11'd0)
            return {res[63], 63'd0};
        return res;
    endfunction

    function automatic int ref_lat(input logic [63:0] x, input logic [63:0] y);
        return (is_norm(x) && is_norm(y)) ? 58 : 1;
    endfunction

`ifdef DDIV_ITER_FLAGS_EN
    function automatic logic [4:0] ref_flags(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] res;
        longint unsigned ma, mb;
        bit zx, zy, ix, iy, sx, sy, nv, dz, of, uf, nx;
        zx = x[62:52] == 11'd0;  zy = y[62:52] == 11'd0;
        ix = x[62:52] == 11'h7FF && x[51:0] == 52'd0;
        iy = y[62:52] == 11'h7FF && y[51:0] == 52'd0;
        sx = is_nan(x) && !x[51]; sy = is_nan(y) && !y[51];
        nv = sx || sy || (zx && zy) || (ix && iy);
        dz = is_norm(x) && zy;
        of = 0; uf = 0; nx = 0;
        if (is_norm(x) && is_norm(y)) begin
            res = ref_div(x, y);
            of  = res[62:52] == 11'h7FF;
            uf  = res[62:52] == 11'd0;
            ma  = {12'd1, x[51:0]};
            mb  = {12'd1, y[51:0]};
            while (mb[0] == 1'b0) mb = mb >> 1;
            nx  = of || uf || (ma % mb != 0);
        end
        return {nv, dz, of, uf, nx};
    endfunction
`endif

    function automatic logic [63:0] rnd_op();
        logic [63:0] x;
        int k;
        x = {$urandom, $urandom};
        k = $urandom_range(0, 9);
        case (k)
            0:       x[62:52] = 11'd0;
            1: begin
                x[62:52] = 11'h7FF;
                if ($urandom_range(0, 1) == 0) x[51:0] = 52'd0;
            end
            2, 3:    x[62:52] = 11'($urandom_range(1, 2046));
            default: x[62:52] = 11'(963 + $urandom_range(0, 120));
        endcase
        return x;
    endfunction

    task automatic run_op(input logic [63:0] xa, input logic [63:0] xb,
                          input logic [63:0] want, input string tag);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        chk($sformatf("%s in_ready", tag), 64'(in_ready), 64'd1);
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk($sformatf("%s latency", tag), 64'(lat), 64'(ref_lat(xa, xb)));
        chk($sformatf("%s out %h/%h", tag, xa, xb), out, want);
`ifdef DDIV_ITER_FLAGS_EN
        chk($sformatf("%s fflags", tag), 64'(fflags), 64'(ref_flags(xa, xb)));
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] xa, xb;
        int w;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out", out, 64'h0);
`ifdef DDIV_ITER_FLAGS_EN
        chk("reset fflags", 64'(fflags), 64'd0);
`endif

        run_op(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, "6/2");
        run_op(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, "1/3");
        run_op(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, "1/0");
        run_op(64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, "0/0");
        run_op(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, "ovf");
        run_op(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, "ufl");
        run_op(64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, "-inf/2");
        run_op(64'h4000000000000000, 64'h7FF0000000000000, 64'h0000000000000000, "2/inf");

        // Backpressure: result held with a pending request that must not be taken.
        out_ready = 1'b0;
        a = 64'h4018000000000000; b = 64'h4000000000000000; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 64'h3FF0000000000000; b = 64'h0000000000000000;
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        chk("bp latency", 64'(w), 64'd58);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold out %0d", i), out, 64'h4008000000000000);
            chk($sformatf("bp hold valid %0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp hold in_ready %0d", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp retire valid", 64'(out_valid), 64'd0);
        chk("bp retire in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp next accepted", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp next valid", 64'(out_valid), 64'd1);
        chk("bp next out", out, 64'h7FF0000000000000);
        @(posedge clk); #1;

        // Reset in the middle of the iteration.
        a = 64'h4018000000000000; b = 64'h4000000000000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        run_op(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, "post-rst 6/2");

        for (int i = 0; i < 40; i++) begin
            xa = rnd_op();
            xb = rnd_op();
            run_op(xa, xb, ref_div(xa, xb), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
